ask4_symbol_source: RTL and testbench



---
 rtl/ask4_pkg.sv | 39 +++
 rtl/prbs15_gen.sv | 49 ++++
 rtl/ask4_symbol_source.sv | 112 +++++++++++
 tb/tb_ask4_symbol_source.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask4_pkg.sv
// Shared types, Gray-coded 4-ASK level constants and the symbol-to-level mapper
// for the ask4_symbol_source stimulus block.
package ask4_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        IMPULSE = 2'b01,
        PRBS    = 2'b10,
        CONST   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ALIGN = 2'b00,
        RUN   = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int LEVEL_W = 18;

    // 1s17 levels: 0.75 and 0.25 of full scale, both signs.
    localparam logic signed [LEVEL_W-1:0] LVL_N3 = -18'sd98303;
    localparam logic signed [LEVEL_W-1:0] LVL_N1 = -18'sd32768;
    localparam logic signed [LEVEL_W-1:0] LVL_P1 =  18'sd32768;
    localparam logic signed [LEVEL_W-1:0] LVL_P3 =  18'sd98303;

    localparam logic [1:0] CONST_SYM = 2'b10;

    function automatic logic signed [LEVEL_W-1:0] gray_to_level(input logic [1:0] sym);
        logic signed [LEVEL_W-1:0] level;
        case (sym)
            2'b00:   level = LVL_N3;
            2'b01:   level = LVL_N1;
            2'b11:   level = LVL_P1;
            default: level = LVL_P3;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/prbs15_gen.sv
// PRBS15 (x^15 + x^14 + 1, Fibonacci) producing two bits per advance, with
// seed reload on request and automatic recovery from the all-zero lock state.
module prbs15_gen #(
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [1:0] bits_o
);

    if (SEED == 15'd0) begin : g_bad_seed
        $error("prbs15_gen: SEED must be nonzero");
    end

    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;
    logic [14:0] base;
    logic [14:0] step1;
    logic        bit1;
    logic        bit2;

    // A load coinciding with an advance starts from the seed, and a locked
    // register is treated as the seed so the stream can never stick at zero.
    always_comb begin
        base   = (load_i || lfsr_q == 15'd0) ? SEED : lfsr_q;
        bit1   = base[14] ^ base[13];
        step1  = {base[13:0], bit1};
        bit2   = step1[14] ^ step1[13];
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {step1[13:0], bit2};
        end else if (load_i) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bits_o = {bit1, bit2};

endmodule

// File: rtl/ask4_symbol_source.sv
// 4-ASK symbol source: PRBS / constant / impulse symbols, Gray-mapped to 1s17
// levels and upsampled by SPS at the sample strobe, feeding the shaping filter.
module ask4_symbol_source
    import ask4_pkg::*;
#(
    parameter int                       WIDTH      = 18,
    parameter int                       SPS        = 4,
    parameter logic [14:0]              LFSR_SEED  = 15'h7FFF,
    parameter logic signed [WIDTH-1:0]  IMP_AMP    = 18'sd98303,
    parameter bit                       ZERO_STUFF = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic [1:0]               mode,
    output logic signed [WIDTH-1:0]  x_out,
    output logic [1:0]               sym_out,
    output logic                     sym_valid,
    output logic [$clog2(SPS)-1:0]   phase
);

    localparam int PW = $clog2(SPS);

    if (WIDTH < 18) begin : g_bad_width
        $error("ask4_symbol_source: WIDTH below 18 is unsupported");
    end
    if (SPS < 2) begin : g_bad_sps
        $error("ask4_symbol_source: SPS must be at least 2");
    end

    mode_t                    modeIn;
    mode_t                    curMode_q;
    state_t                   state_q;
    logic [PW-1:0]            phase_q;
    logic signed [WIDTH-1:0]  x_q;
    logic [1:0]               sym_q;
    logic                     valid_q;

    logic                     modeChange;
    logic                     launch;
    logic                     prbsLoad;
    logic                     prbsAdv;
    logic [1:0]               prbsBits;
    logic [1:0]               launchSym;

    // A mode change is only acted on at a sample strobe; while aligning the new
    // mode is simply adopted, so a coincident symbol strobe still launches.
    always_comb begin
        modeIn     = mode_t'(mode);
        modeChange = (modeIn != curMode_q);
        launch     = sam_clk_en && sym_clk_en && (modeIn != OFF) &&
                     ((state_q == ALIGN) || (state_q == RUN && !modeChange));
        prbsLoad   = sam_clk_en && modeChange && (modeIn == PRBS);
        prbsAdv    = launch && (modeIn == PRBS);
        launchSym  = (modeIn == PRBS) ? prbsBits : CONST_SYM;
    end

    prbs15_gen #(
        .SEED (LFSR_SEED)
    ) u_prbs (
        .clk_i  (sys_clk),
        .rst_i  (reset),
        .load_i (prbsLoad),
        .adv_i  (prbsAdv),
        .bits_o (prbsBits)
    );

    // FSM, phase counter and output registers; sym_valid is the only state
    // that moves outside the sample strobe, so it drops after one clock.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ALIGN;
            curMode_q <= OFF;
            phase_q   <= '0;
            x_q       <= '0;
            sym_q     <= 2'b00;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= launch;
            if (sam_clk_en) begin
                curMode_q <= modeIn;
                if (sym_clk_en || modeChange) begin
                    phase_q <= '0;
                end else if (phase_q != PW'(SPS - 1)) begin
                    phase_q <= phase_q + 1'b1;
                end
                if (launch) begin
                    if (modeIn == IMPULSE) begin
                        state_q <= DONE;
                        x_q     <= IMP_AMP;
                    end else begin
                        state_q <= RUN;
                        sym_q   <= launchSym;
                        x_q     <= WIDTH'(gray_to_level(launchSym));
                    end
                end else if (modeChange || state_q != RUN) begin
                    state_q <= (state_q == DONE && !modeChange) ? DONE : ALIGN;
                    x_q     <= '0;
                end else begin
                    x_q <= ZERO_STUFF ? '0 : WIDTH'(gray_to_level(sym_q));
                end
            end
        end
    end

    assign x_out     = x_q;
    assign sym_out   = sym_q;
    assign sym_valid = valid_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Scoreboard bench for ask4_symbol_source: a zero-stuffing and a level-holding
// instance share random stimulus and are checked against a behavioural model.
module tb_ask4_symbol_source;

    localparam int SPS       = 4;
    localparam int SEED      = 'h7FFF;
    localparam int IMP       = 98303;
    localparam int M_OFF     = 0;
    localparam int M_IMPULSE = 1;
    localparam int M_PRBS    = 2;
    localparam int M_CONST   = 3;

    typedef struct {
        int xStuff;
        int xHold;
        bit valid;
        int sym;
        int phase;
    } exp_t;

    logic              sys_clk    = 1'b0;
    logic              reset      = 1'b0;
    logic              sam_clk_en = 1'b0;
    logic              sym_clk_en = 1'b0;
    logic [1:0]        mode       = 2'b00;
    logic signed [17:0] xZs, xHold;
    logic [1:0]        symZs, symHold;
    logic              validZs, validHold;
    logic [1:0]        phaseZs, phaseHold;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: "running" means a symbol stream has been started since
    // the last alignment, "spent" means the one-shot impulse has been used.
    int   modelMode;
    bit   running;
    bit   spent;
    int   modelLfsr;
    int   lastSym;
    int   modelPhase;
    int   levelOf[4] = '{-98303, -32768, 98303, 32768};

    ask4_symbol_source #(.ZERO_STUFF(1'b1)) dutZs (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .mode       (mode),
        .x_out      (xZs),
        .sym_out    (symZs),
        .sym_valid  (validZs),
        .phase      (phaseZs)
    );

    ask4_symbol_source #(.ZERO_STUFF(1'b0)) dutHold (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .mode       (mode),
        .x_out      (xHold),
        .sym_out    (symHold),
        .sym_valid  (validHold),
        .phase      (phaseHold)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelMode  = M_OFF;
        running    = 1'b0;
        spent      = 1'b0;
        modelLfsr  = SEED;
        lastSym    = 0;
        modelPhase = 0;
    endtask

    task automatic prbsBit(output int nb);
        nb        = ((modelLfsr >> 14) ^ (modelLfsr >> 13)) & 1;
        modelLfsr = ((modelLfsr << 1) | nb) & 'h7FFF;
    endtask

    task automatic nextPrbsSymbol(output int s);
        int b1, b2;
        if (modelLfsr == 0) modelLfsr = SEED;
        prbsBit(b1);
        prbsBit(b2);
        s = b1 * 2 + b2;
    endtask

    task automatic modelSample(input int m, input bit sym, output exp_t e);
        bit changed;
        int s;
        changed = (m != modelMode);
        e.valid  = 1'b0;
        e.xStuff = 0;
        e.xHold  = 0;
        if (sym || changed) modelPhase = 0;
        else if (modelPhase < SPS - 1) modelPhase++;
        if (changed && m == M_PRBS) modelLfsr = SEED;
        modelMode = m;
        if (running && changed) begin
            running = 1'b0;
            spent   = 1'b0;
        end else if (sym && m != M_OFF && !spent) begin
            running = 1'b1;
            e.valid = 1'b1;
            if (m == M_IMPULSE) begin
                spent    = 1'b1;
                e.xStuff = IMP;
                e.xHold  = IMP;
            end else begin
                if (m == M_PRBS) nextPrbsSymbol(s);
                else s = 2;
                lastSym  = s;
                e.xStuff = levelOf[s];
                e.xHold  = levelOf[s];
            end
        end else if (running && !spent) begin
            e.xHold = levelOf[lastSym];
        end
        e.sym   = lastSym;
        e.phase = modelPhase;
    endtask

    task automatic applyStimulus(input bit sam, input bit sym, input int m);
        exp_t e;
        @(negedge sys_clk);
        sam_clk_en = sam;
        sym_clk_en = sam & sym;
        mode       = 2'(m);
        if (sam) begin
            modelSample(m, sym, e);
            expQ.push_back(e);
        end
    endtask

    task automatic sendSample(input int m, input bit sym);
        applyStimulus(1'b1, sym, m);
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, m);
    endtask

    task automatic runSymbols(input int n, input int m);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = SPS;
            if ($urandom_range(0, 7) == 0) gap = SPS + $urandom_range(1, 2);
            for (int k = 0; k < gap; k++) sendSample(m, k == 0);
        end
    endtask

    task automatic partialSymbol(input int m, input int k);
        for (int j = 0; j <= k; j++) sendSample(m, j == 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, " x_out stuffed"}, int'(xZs), 0);
        checkVal({tag, " x_out hold"}, int'(xHold), 0);
        checkVal({tag, " sym_out"}, int'(symZs), 0);
        checkVal({tag, " sym_valid"}, int'(validZs), 0);
        checkVal({tag, " phase"}, int'(phaseZs), 0);
    endtask

    task automatic doReset();
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        checkVal("queue empty before reset", expQ.size(), 0);
        #2 reset = 1'b1;
        #1 checkResetValues("async reset");
        modelReset();
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        checkVal("x_out stuffed", int'(xZs), e.xStuff);
        checkVal("x_out hold", int'(xHold), e.xHold);
        checkVal("sym_valid", int'(validZs), int'(e.valid));
        checkVal("sym_valid hold", int'(validHold), int'(e.valid));
        checkVal("phase", int'(phaseZs), e.phase);
        checkVal("sym_out", int'(symZs), e.sym);
    endtask

    initial begin : monitor
        exp_t e;
        bit   sampled;
        forever begin
            @(posedge sys_clk);
            sampled = sam_clk_en && !reset;
            #1;
            if (sampled) begin
                if (expQ.size() == 0) begin
                    checkVal("scoreboard underflow", 0, 1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e);
                end
            end else if (!reset) begin
                checkVal("sym_valid idle", int'(validZs), 0);
                checkVal("sym_valid idle hold", int'(validHold), 0);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        modelReset();
        reset = 1'b1;
        repeat (2) @(negedge sys_clk);
        checkResetValues("power-on");
        reset = 1'b0;

        // PRBS from reset: zeros until the first symbol strobe, then the golden stream
        repeat (3) sendSample(M_PRBS, 1'b0);
        runSymbols(1000, M_PRBS);

        // Reset in the middle of a symbol, then restart
        partialSymbol(M_PRBS, 2);
        doReset();
        repeat (2) sendSample(M_PRBS, 1'b0);
        runSymbols(20, M_PRBS);

        // PRBS -> OFF -> PRBS at phase 2 restarts the seed sequence
        partialSymbol(M_PRBS, 2);
        sendSample(M_OFF, 1'b0);
        sendSample(M_OFF, 1'b1);
        sendSample(M_PRBS, 1'b0);
        runSymbols(20, M_PRBS);

        runSymbols(30, M_CONST);
        runSymbols(60, M_IMPULSE);

        // Lock-guard: zero the LFSR between symbols
        runSymbols(5, M_PRBS);
        applyStimulus(1'b0, 1'b0, M_PRBS);
        force dutZs.u_prbs.lfsr_q = 15'd0;
        force dutHold.u_prbs.lfsr_q = 15'd0;
        modelLfsr = 0;
        applyStimulus(1'b0, 1'b0, M_PRBS);
        release dutZs.u_prbs.lfsr_q;
        release dutHold.u_prbs.lfsr_q;
        runSymbols(30, M_PRBS);

        for (int it = 0; it < 40; it++) begin
            int m;
            m = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) partialSymbol(m, $urandom_range(0, 3));
            else runSymbols($urandom_range(1, 8), m);
        end

        repeat (4) applyStimulus(1'b0, 1'b0, M_OFF);
        checkVal("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
